// File: rtl/traffic_pkg.sv
// Shared light encodings, fault codes and monitor states for the traffic safety monitor.
package traffic_pkg;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] OFF = 3'b000;

  localparam logic [2:0] FC_NONE      = 3'd0;
  localparam logic [2:0] FC_ENCODING  = 3'd1;
  localparam logic [2:0] FC_CONFLICT  = 3'd2;
  localparam logic [2:0] FC_GRN_RED   = 3'd3;
  localparam logic [2:0] FC_SHORT_YEL = 3'd4;

  typedef enum logic [0:0] {
    MONITOR     = 1'b0,
    FAULT_FLASH = 1'b1
  } state_t;

  function automatic logic is_legal(input logic [2:0] light);
    return (light == RED) || (light == YEL) || (light == GRN);
  endfunction

endpackage

// File: rtl/approach_checker.sv
// Per-approach sequence checker: keeps the previous light and a saturating yellow
// counter, and flags illegal encodings, green-to-red jumps and short yellows.
module approach_checker
  import traffic_pkg::*;
#(
  parameter int MIN_YELLOW = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] light_in,
  input  logic       reload,
  output logic       err_encoding,
  output logic       err_grn_red,
  output logic       err_short_yel
);

  localparam int            CW      = $clog2(MIN_YELLOW + 1);
  localparam logic [CW-1:0] YEL_SAT = CW'(MIN_YELLOW);

  logic [2:0]    prev_reg;
  logic [CW-1:0] yel_cnt_reg;
  logic [CW-1:0] yel_cnt_next;

  // The counter is zero whenever the previous light was not yellow, so +1 starts a run at 1.
  always_comb begin
    yel_cnt_next = '0;
    if (light_in == YEL) begin
      if (reload)
        yel_cnt_next = CW'(1);
      else if (yel_cnt_reg == YEL_SAT)
        yel_cnt_next = YEL_SAT;
      else
        yel_cnt_next = yel_cnt_reg + 1'b1;
    end
  end

  assign err_encoding  = !is_legal(light_in);
  assign err_grn_red   = (prev_reg == GRN) && (light_in == RED);
  assign err_short_yel = (prev_reg == YEL) && (light_in == RED) && (yel_cnt_reg < YEL_SAT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_reg    <= RED;
      yel_cnt_reg <= '0;
    end else begin
      prev_reg    <= light_in;
      yel_cnt_reg <= yel_cnt_next;
    end
  end

endmodule

// File: rtl/traffic_safety_monitor.sv
// Safety monitor between a traffic controller and its lamps: passes lights through
// with one cycle of latency and falls back to a flashing-red state on any fault.
module traffic_safety_monitor
  import traffic_pkg::*;
#(
  parameter int MIN_YELLOW = 3,
  parameter int FLASH_HALF = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] light_M1_in,
  input  logic [2:0] light_S_in,
  input  logic [2:0] light_M2_in,
  input  logic [2:0] light_MT_in,
  input  logic       clear_fault,
  output logic [2:0] light_M1,
  output logic [2:0] light_S,
  output logic [2:0] light_M2,
  output logic [2:0] light_MT,
  output logic       fault,
  output logic [2:0] fault_code
);

  localparam int            TW         = $clog2(2 * FLASH_HALF + 1);
  localparam logic [TW-1:0] FLASH_ON   = TW'(FLASH_HALF);
  localparam logic [TW-1:0] FLASH_LAST = TW'(2 * FLASH_HALF - 1);

  // Approach index order: 0 = M1, 1 = S, 2 = M2, 3 = MT.
  logic [2:0]    light_in_arr [4];
  logic [2:0]    out_reg      [4];
  logic [3:0]    err_enc, err_gr, err_sy, non_red;
  logic          conflict, all_red_in, clear_ok;
  logic [2:0]    code_det;
  state_t        state_reg;
  logic [2:0]    code_reg;
  logic [TW-1:0] flash_reg;

  assign light_in_arr[0] = light_M1_in;
  assign light_in_arr[1] = light_S_in;
  assign light_in_arr[2] = light_M2_in;
  assign light_in_arr[3] = light_MT_in;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_appr
      approach_checker #(.MIN_YELLOW(MIN_YELLOW)) u_chk (
        .clk          (clk),
        .rst          (rst),
        .light_in     (light_in_arr[gi]),
        .reload       (clear_ok),
        .err_encoding (err_enc[gi]),
        .err_grn_red  (err_gr[gi]),
        .err_short_yel(err_sy[gi])
      );
      assign non_red[gi] = (light_in_arr[gi] != RED);
    end
  endgenerate

  // M1 may run with M2 or MT; M2/MT are mutually exclusive; S runs alone.
  assign conflict   = (non_red[2] && non_red[3]) ||
                      (non_red[1] && (non_red[0] || non_red[2] || non_red[3]));
  assign all_red_in = (non_red == 4'b0000);
  assign clear_ok   = (state_reg == FAULT_FLASH) && clear_fault && all_red_in;

  always_comb begin
    code_det = FC_NONE;
    if (|err_enc)      code_det = FC_ENCODING;
    else if (conflict) code_det = FC_CONFLICT;
    else if (|err_gr)  code_det = FC_GRN_RED;
    else if (|err_sy)  code_det = FC_SHORT_YEL;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= MONITOR;
      code_reg  <= FC_NONE;
      flash_reg <= '0;
      for (int i = 0; i < 4; i++) out_reg[i] <= RED;
    end else begin
      case (state_reg)
        MONITOR: begin
          if (code_det != FC_NONE) begin
            // Entry cycle is the first on-phase cycle, so the timer resumes at index 1.
            state_reg <= FAULT_FLASH;
            code_reg  <= code_det;
            flash_reg <= TW'(1);
            for (int i = 0; i < 4; i++) out_reg[i] <= RED;
          end else begin
            for (int i = 0; i < 4; i++) out_reg[i] <= light_in_arr[i];
          end
        end
        FAULT_FLASH: begin
          if (clear_ok) begin
            state_reg <= MONITOR;
            code_reg  <= FC_NONE;
            flash_reg <= '0;
            for (int i = 0; i < 4; i++) out_reg[i] <= light_in_arr[i];
          end else begin
            flash_reg <= (flash_reg == FLASH_LAST) ? '0 : flash_reg + 1'b1;
            for (int i = 0; i < 4; i++) out_reg[i] <= (flash_reg < FLASH_ON) ? RED : OFF;
          end
        end
        default: state_reg <= MONITOR;
      endcase
    end
  end

  assign light_M1   = out_reg[0];
  assign light_S    = out_reg[1];
  assign light_M2   = out_reg[2];
  assign light_MT   = out_reg[3];
  assign fault      = (state_reg == FAULT_FLASH);
  assign fault_code = code_reg;

endmodule

// File: doc/traffic_safety_monitor.md
TRAFFIC_SAFETY_MONITOR -- requirements
Module: traffic_safety_monitor

Interface
REQ-001 The module SHALL have parameter MIN_YELLOW, default 3, meaning the minimum number of consecutive cycles an approach must show yellow before red.
REQ-002 The module SHALL have parameter FLASH_HALF, default 2, meaning the number of cycles in each on phase and each off phase of the fail-safe flash.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have ports light_M1_in, light_S_in, light_M2_in, light_MT_in, input, 3 bits each: raw lights from the controller, encoded {red,yellow,green}.
REQ-006 The module SHALL have input clear_fault, 1 bit: operator request to leave the fail-safe state.
REQ-007 The module SHALL have ports light_M1, light_S, light_M2, light_MT, output, 3 bits each: the lights actually driven to the lamps.
REQ-008 The module SHALL have output fault, 1 bit: high while in the fail-safe state.
REQ-009 The module SHALL have output fault_code, 3 bits: the first fault detected since the last clear (0 means none).

Function
REQ-010 In MONITOR, each output SHALL equal the corresponding input registered once, giving 1-cycle latency.
REQ-011 Legal input encodings SHALL be 3'b100 (red), 3'b010 (yellow) and 3'b001 (green); any other encoding SHALL raise fault code 1.
REQ-012 Compatibility: M1 may be non-red together with M2 or with MT; M2 and MT non-red together SHALL raise code 2; S non-red with any other non-red approach SHALL raise code 2.
REQ-013 Any approach that goes green to red in consecutive cycles, with no yellow between, SHALL raise code 3.
REQ-014 A per-approach yellow counter SHALL count consecutive yellow cycles, starting at 1 on the first yellow cycle, and SHALL saturate at MIN_YELLOW.
REQ-015 A yellow-to-red transition while the yellow count is below MIN_YELLOW SHALL raise code 4.
REQ-016 When faults occur in the same cycle, the lowest code SHALL win.
REQ-017 Detection happens in cycle N; in cycle N+1 the state SHALL be FAULT_FLASH, fault SHALL be 1 and fault_code SHALL be latched.
REQ-018 In FAULT_FLASH, all four outputs SHALL show 3'b100 for FLASH_HALF cycles, then 3'b000 for FLASH_HALF cycles, repeating; the first cycle of the state SHALL be an on phase.
REQ-019 New faults raised while in FAULT_FLASH SHALL NOT change fault_code.
REQ-020 clear_fault sampled high SHALL return the block to MONITOR only when all four inputs equal 3'b100 in that same cycle; otherwise it SHALL be ignored.
REQ-021 On that clear, fault and fault_code SHALL go to 0 on the next edge, and the history and yellow counters SHALL be reloaded from the current inputs.
REQ-022 The history registers (previous light per approach) SHALL update every cycle in both states.

Reset
REQ-023 While rst=0, all outputs SHALL be 3'b100, fault SHALL be 0, fault_code SHALL be 0, the state SHALL be MONITOR, history SHALL be red, and counters and flash timer SHALL be 0.
REQ-024 Reset assertion SHALL take effect immediately, regardless of the clock, including mid-flash or mid-yellow.
REQ-025 The first edge after rst goes high SHALL evaluate the inputs against a red history.

Structure
REQ-026 A shared package traffic_pkg SHALL hold: the light encodings RED, YEL, GRN and OFF; the fault codes; and the state enum {MONITOR, FAULT_FLASH}.
REQ-027 A sub-module approach_checker SHALL be instantiated four times; each instance holds one approach's history and yellow counter and flags codes 1, 3 and 4.
REQ-028 The top level SHALL own the conflict check, the priority encoding, the FSM and the flash timer.

Verification
REQ-029 Legal cycle (M1/M2 green 5, M2 yellow 3, M2 red, MT green) -> outputs track inputs 1 cycle late, fault=0.
REQ-030 M2=001 and MT=001 in cycle 10 -> cycle 11: fault=1, fault_code=2, all outputs 100; cycles 13-14: outputs 000; cycle 15: outputs 100.
REQ-031 M1 001 -> 100 directly -> fault_code=3; M1 yellow for 2 cycles then red -> fault_code=4; with MIN_YELLOW=3, 3 yellow cycles -> no fault.
REQ-032 S=011 together with an M1/MT conflict in the same cycle -> fault_code=1.
REQ-033 In FAULT: clear_fault with M1=001 -> stays in FAULT; clear_fault with all inputs 100 -> next cycle fault=0, code=0, outputs 100.
REQ-034 rst pulled low between edges during flash -> outputs 100 and fault=0 immediately, with no clock edge.
